// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared types and helpers for the native-to-Wishbone bridge
//   port_state_t : per-channel FSM states
//   timeout_w()  : timeout counter width for a given TIMEOUT_CYCLES (min 1 bit)
package wb_bridge_pkg;
    typedef enum logic [1:0] {IDLE, BUS, DRAIN} port_state_t;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int TIMEOUT_W = $clog2(DEF_TIMEOUT_CYCLES + 1);
    function automatic int timeout_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/wb_bridge_port.sv
// wb_bridge_port: one native request channel driving one Wishbone master
//   req_*  : native request in, req_ready = channel idle
//   resp_* : single-cycle response pulse with rdata/err
//   wb_*   : Wishbone master signals (classic or pipelined)
module wb_bridge_port
    import wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int PIPELINED      = 0,
    parameter int RESP_STAGES    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_en,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [SEL_WIDTH-1:0]  req_strobe,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [SEL_WIDTH-1:0]  wb_sel,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack,
    input  logic                  wb_stall
);
    localparam int TW = timeout_w(TIMEOUT_CYCLES);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } resp_t;
    port_state_t state_q, state_d;
    logic stb_q, stb_d, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [TW-1:0] cnt_q;
    logic accept, expire, done;
    resp_t resp_now;
    assign req_ready = state_q == IDLE;
    assign accept = req_en && req_ready;
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    // an ack in the expiry cycle still counts as a normal completion
    assign done = (state_q == BUS) && (wb_ack || expire);
    assign resp_now = {(wb_ack && !we_q) ? wb_dat_i : {DATA_WIDTH{1'b0}}, !wb_ack};
    assign wb_cyc = state_q == BUS;
    assign wb_stb = wb_cyc && stb_q;
    assign wb_we = we_q;
    assign wb_sel = sel_q;
    assign wb_addr = addr_q;
    assign wb_dat_o = wdata_q;
    always_comb begin
        state_d = accept ? BUS :
                  done ? ((RESP_STAGES == 0) ? IDLE : DRAIN) :
                  (state_q == DRAIN && resp_valid) ? IDLE : state_q;
        // pipelined: the strobe is retired once the slave takes it (stall low)
        stb_d = accept ? 1'b1 : ((PIPELINED != 0) && wb_stb && !wb_stall) ? 1'b0 : stb_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            cnt_q   <= accept ? '0 : (state_q == BUS) ? cnt_q + TW'(1) : cnt_q;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                sel_q   <= req_strobe;
            end
        end
    end
    if (RESP_STAGES == 0) begin : g_comb
        assign resp_valid = done;
        assign resp_rdata = done ? resp_now.rdata : '0;
        assign resp_err   = done && resp_now.err;
    end else begin : g_reg
        logic [RESP_STAGES-1:0] v_q;
        resp_t [RESP_STAGES-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
                r_q <= '0;
            end else begin
                for (int i = RESP_STAGES - 1; i > 0; i--) begin
                    v_q[i] <= v_q[i-1];
                    r_q[i] <= r_q[i-1];
                end
                v_q[0] <= done;
                r_q[0] <= done ? resp_now : '0;
            end
        end
        assign resp_valid = v_q[RESP_STAGES-1];
        assign resp_rdata = r_q[RESP_STAGES-1].rdata;
        assign resp_err   = r_q[RESP_STAGES-1].err;
    end
endmodule

// File: rtl/wb_native_bridge.sv
// wb_native_bridge: NUM_PORTS independent native-port to Wishbone master channels
//   ch0 = instruction bus, ch1 = data bus; per-channel signals are flat packed
//   vectors with channel i at [i*W +: W]
module wb_native_bridge #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINED      = 0,
    parameter int RESP_STAGES    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_en,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_strobe,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata,
    output logic [NUM_PORTS-1:0]            resp_err,
    output logic [NUM_PORTS-1:0]            wb_cyc,
    output logic [NUM_PORTS-1:0]            wb_stb,
    output logic [NUM_PORTS-1:0]            wb_we,
    output logic [NUM_PORTS*DATA_WIDTH/8-1:0] wb_sel,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] wb_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] wb_dat_o,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wb_dat_i,
    input  logic [NUM_PORTS-1:0]            wb_ack,
    input  logic [NUM_PORTS-1:0]            wb_stall
);
    localparam int SW = DATA_WIDTH / 8;
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        wb_bridge_port #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .SEL_WIDTH(SW),
            .PIPELINED(PIPELINED),
            .RESP_STAGES(RESP_STAGES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_port (
            .clk(clk),
            .rst_n(rst_n),
            .req_en(req_en[i]),
            .req_ready(req_ready[i]),
            .req_we(req_we[i]),
            .req_addr(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .req_wdata(req_wdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .req_strobe(req_strobe[i*SW +: SW]),
            .resp_valid(resp_valid[i]),
            .resp_rdata(resp_rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .resp_err(resp_err[i]),
            .wb_cyc(wb_cyc[i]),
            .wb_stb(wb_stb[i]),
            .wb_we(wb_we[i]),
            .wb_sel(wb_sel[i*SW +: SW]),
            .wb_addr(wb_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .wb_dat_o(wb_dat_o[i*DATA_WIDTH +: DATA_WIDTH]),
            .wb_dat_i(wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .wb_ack(wb_ack[i]),
            .wb_stall(wb_stall[i])
        );
    end
endmodule

// File: tb/tb_wb_native_bridge.sv
// tb_wb_native_bridge: scoreboard bench for a classic/1-port and a pipelined/2-port bridge
module tb_wb_native_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [0:0]  a_req_en, a_req_ready, a_req_we, a_resp_valid, a_resp_err;
    logic [0:0]  a_wb_cyc, a_wb_stb, a_wb_we, a_wb_ack, a_wb_stall;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_wb_addr, a_wb_dat_o, a_wb_dat_i;
    logic [3:0]  a_req_strobe, a_wb_sel;

    logic [1:0]  b_req_en, b_req_ready, b_req_we, b_resp_valid, b_resp_err;
    logic [1:0]  b_wb_cyc, b_wb_stb, b_wb_we, b_wb_ack, b_wb_stall;
    logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata, b_wb_addr, b_wb_dat_o, b_wb_dat_i;
    logic [7:0]  b_req_strobe, b_wb_sel;

    wb_native_bridge #(.NUM_PORTS(1), .PIPELINED(0), .RESP_STAGES(0), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_en(a_req_en), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_strobe(a_req_strobe),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .wb_cyc(a_wb_cyc), .wb_stb(a_wb_stb), .wb_we(a_wb_we), .wb_sel(a_wb_sel),
        .wb_addr(a_wb_addr), .wb_dat_o(a_wb_dat_o), .wb_dat_i(a_wb_dat_i),
        .wb_ack(a_wb_ack), .wb_stall(a_wb_stall));

    wb_native_bridge #(.NUM_PORTS(2), .PIPELINED(1), .RESP_STAGES(2), .TIMEOUT_CYCLES(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_en(b_req_en), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strobe(b_req_strobe),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .wb_cyc(b_wb_cyc), .wb_stb(b_wb_stb), .wb_we(b_wb_we), .wb_sel(b_wb_sel),
        .wb_addr(b_wb_addr), .wb_dat_o(b_wb_dat_o), .wb_dat_i(b_wb_dat_i),
        .wb_ack(b_wb_ack), .wb_stall(b_wb_stall));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t sbq[3][$];
    int vec = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [31:0] rd, input logic err, input int at);
        exp_t e;
        e.rdata = rd;
        e.err = err;
        e.at = at;
        sbq[k].push_back(e);
    endtask

    task automatic mon(input int k, input logic [31:0] rd, input logic err);
        exp_t e;
        if (sbq[k].size() == 0) begin
            chk($sformatf("unexpected resp_valid sb%0d", k), 64'd1, 64'd0);
            return;
        end
        e = sbq[k].pop_front();
        chk($sformatf("rdata sb%0d", k), 64'(rd), 64'(e.rdata));
        chk($sformatf("err sb%0d", k), 64'(err), 64'(e.err));
        chk($sformatf("resp cycle sb%0d", k), 64'(cyc), 64'(e.at));
    endtask

    always @(negedge clk) if (rst_n) begin
        if (a_resp_valid[0]) mon(0, a_resp_rdata, a_resp_err[0]);
        if (b_resp_valid[0]) mon(1, b_resp_rdata[31:0], b_resp_err[0]);
        if (b_resp_valid[1]) mon(2, b_resp_rdata[63:32], b_resp_err[1]);
    end

    int a_stb_tot = 0, a_cyc_tot = 0, b_stb_tot = 0, b_cyc_tot = 0;
    always @(negedge clk) begin
        a_stb_tot += int'(a_wb_stb[0]);
        a_cyc_tot += int'(a_wb_cyc[0]);
        b_stb_tot += int'(b_wb_stb[1]);
        b_cyc_tot += int'(b_wb_cyc[1]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] sel, output int c0);
        a_req_en = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_strobe = sel;
        c0 = cyc;
        step(1);
        a_req_en = 1'b0; a_req_we = ~we; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = '1; a_req_strobe = '0;
    endtask

    int c0, s0, s1;

    initial begin
        a_req_en = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0; a_req_strobe = '0;
        a_wb_dat_i = '0; a_wb_ack = '0; a_wb_stall = '0;
        b_req_en = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0; b_req_strobe = '0;
        b_wb_dat_i = '0; b_wb_ack = '0; b_wb_stall = '0;
        step(2);
        chk("reset ready a", 64'(a_req_ready), 64'h1);
        chk("reset cyc a", 64'(a_wb_cyc), 64'h0);
        chk("reset resp a", 64'(a_resp_valid), 64'h0);
        chk("reset ready b", 64'(b_req_ready), 64'h3);
        chk("reset cyc b", 64'(b_wb_cyc), 64'h0);
        chk("reset stb b", 64'(b_wb_stb), 64'h0);
        rst_n = 1'b1;
        step(2);

        // classic read, 3 wait states
        s0 = a_stb_tot;
        a_issue(1'b0, 32'h100, 32'h0, 4'hF, c0);
        chk("A rd addr", 64'(a_wb_addr), 64'h100);
        chk("A rd we", 64'(a_wb_we), 64'h0);
        chk("A rd busy", 64'(a_req_ready), 64'h0);
        push(0, 32'hDEADBEEF, 1'b0, c0 + 4);
        step(3);
        a_wb_ack = 1'b1; a_wb_dat_i = 32'hDEADBEEF;
        step(1);
        a_wb_ack = 1'b0; a_wb_dat_i = '0;
        chk("A rd cyc drop", 64'(a_wb_cyc), 64'h0);
        chk("A rd ready back", 64'(a_req_ready), 64'h1);
        chk("A rd stb cycles", 64'(a_stb_tot - s0), 64'd4);

        // classic write, zero wait, inputs changed after accept
        a_issue(1'b1, 32'h200, 32'hCAFE0001, 4'h3, c0);
        chk("A wr we", 64'(a_wb_we), 64'h1);
        chk("A wr addr", 64'(a_wb_addr), 64'h200);
        chk("A wr data", 64'(a_wb_dat_o), 64'hCAFE0001);
        chk("A wr sel", 64'(a_wb_sel), 64'h3);
        a_wb_ack = 1'b1; a_wb_dat_i = 32'h55555555;
        push(0, 32'h0, 1'b0, c0 + 1);
        step(1);
        a_wb_ack = 1'b0; a_wb_dat_i = '0;
        chk("A wr ready back", 64'(a_req_ready), 64'h1);
        step(1);

        // timeout, then stray ack while idle
        s1 = a_cyc_tot;
        a_issue(1'b0, 32'h300, 32'h0, 4'hF, c0);
        push(0, 32'h0, 1'b1, c0 + 8);
        step(11);
        chk("A timeout cyc cycles", 64'(a_cyc_tot - s1), 64'd8);
        chk("A timeout ready", 64'(a_req_ready), 64'h1);
        a_wb_ack = 1'b1; a_wb_dat_i = 32'h77777777;
        step(1);
        a_wb_ack = 1'b0; a_wb_dat_i = '0;
        step(3);

        // ack exactly on the expiry cycle
        a_issue(1'b0, 32'h400, 32'h0, 4'hF, c0);
        push(0, 32'h12345678, 1'b0, c0 + 8);
        step(7);
        a_wb_ack = 1'b1; a_wb_dat_i = 32'h12345678;
        step(1);
        a_wb_ack = 1'b0; a_wb_dat_i = '0;
        chk("A exact cyc drop", 64'(a_wb_cyc), 64'h0);
        step(3);

        // pipelined write on ch1 with 2 stall cycles, 2 response stages
        s0 = b_stb_tot; s1 = b_cyc_tot;
        b_wb_stall[1] = 1'b1;
        b_req_en[1] = 1'b1; b_req_we[1] = 1'b1; b_req_addr[63:32] = 32'h300;
        b_req_wdata[63:32] = 32'h0000BEEF; b_req_strobe[7:4] = 4'b0011;
        c0 = cyc;
        step(1);
        b_req_en[1] = 1'b0; b_req_strobe[7:4] = 4'hF;
        chk("B wr sel", 64'(b_wb_sel[7:4]), 64'h3);
        chk("B wr data", 64'(b_wb_dat_o[63:32]), 64'h0000BEEF);
        push(2, 32'h0, 1'b0, c0 + 7);
        step(2);
        b_wb_stall[1] = 1'b0;
        step(2);
        b_wb_ack[1] = 1'b1; b_wb_dat_i[63:32] = 32'h99999999;
        step(1);
        b_wb_ack[1] = 1'b0; b_wb_dat_i[63:32] = '0;
        step(1);
        chk("B wr busy in resp", 64'(b_req_ready[1]), 64'h0);
        step(1);
        chk("B wr ready back", 64'(b_req_ready[1]), 64'h1);
        chk("B wr stb cycles", 64'(b_stb_tot - s0), 64'd3);
        chk("B wr cyc cycles", 64'(b_cyc_tot - s1), 64'd5);
        step(1);

        // both channels requested together, acked at different cycles
        b_req_en = 2'b11; b_req_we = 2'b00; b_req_addr = {32'h500, 32'h400};
        c0 = cyc;
        step(1);
        b_req_en = 2'b00;
        push(1, 32'hAAAA5555, 1'b0, c0 + 4);
        push(2, 32'h0BADF00D, 1'b0, c0 + 6);
        step(1);
        b_wb_ack[0] = 1'b1; b_wb_dat_i[31:0] = 32'hAAAA5555;
        step(1);
        b_wb_ack[0] = 1'b0; b_wb_dat_i[31:0] = '0;
        chk("B dual ch1 still busy", 64'(b_wb_cyc[1]), 64'h1);
        step(1);
        b_wb_ack[1] = 1'b1; b_wb_dat_i[63:32] = 32'h0BADF00D;
        step(1);
        b_wb_ack[1] = 1'b0; b_wb_dat_i[63:32] = '0;
        step(4);
        chk("B dual ready", 64'(b_req_ready), 64'h3);

        // reset in the middle of a bus cycle
        a_issue(1'b0, 32'h600, 32'h0, 4'hF, c0);
        step(1);
        chk("A pre-reset cyc", 64'(a_wb_cyc), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("A reset cyc", 64'(a_wb_cyc), 64'h0);
        chk("A reset stb", 64'(a_wb_stb), 64'h0);
        chk("A reset ready", 64'(a_req_ready), 64'h1);
        step(1);
        rst_n = 1'b1;
        a_wb_ack = 1'b1; a_wb_dat_i = 32'h31313131;
        step(1);
        a_wb_ack = 1'b0; a_wb_dat_i = '0;
        step(4);

        for (int k = 0; k < 3; k++) chk($sformatf("leftover expected sb%0d", k), 64'(sbq[k].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
